// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
// Firmware and benches use the same glyph table.
package seg7_pkg;

    localparam int DEF_NUM_DIGITS = 10;
    localparam int DEF_SEG_W      = 8;
    localparam int DEF_PRESCALE   = 1000;
    localparam int DEF_BRIGHT_W   = 4;

    // Widest digit count the decode helper supports.
    localparam int MAX_DIGITS = 32;

    // The decode is built at MAX_DIGITS width.
    // Callers truncate it to their own NUM_DIGITS.
    function automatic logic [MAX_DIGITS-1:0] onehot_sel(input logic [31:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

    // Hex glyphs 0-F.
    // Bit order is {dp, g, f, e, d, c, b, a}, and segments are active high.
    localparam logic [7:0] SEG7_GLYPH [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/scan_timebase.sv
// Slot prescaler, digit index and free-running PWM counter for the scanner.
// Also produces the slot-start and frame-end strobes.
module scan_timebase
    import seg7_pkg::*;
#(
    parameter int  NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int  PRESCALE   = DEF_PRESCALE,
    parameter int  BRIGHT_W   = DEF_BRIGHT_W,
    localparam int IDX_W      = $clog2(NUM_DIGITS),
    localparam int PRE_W      = $clog2(PRESCALE)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [IDX_W-1:0]    idx_o,
    output logic [BRIGHT_W-1:0] pwm_cnt_o,
    output logic                slot_start_o,
    output logic                frame_end_o
);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BRIGHT_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                pre_wrap;
    logic                idx_last;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        pre_wrap  = (pre_cnt_q == PRE_W'(PRESCALE - 1));
        idx_last  = (idx_q == IDX_W'(NUM_DIGITS - 1));
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        idx_d     = idx_q;
        pwm_cnt_d = pwm_cnt_q + BRIGHT_W'(1);
        if (pre_wrap) begin
            pre_cnt_d = '0;
            idx_d     = idx_last ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            idx_q     <= '0;
            pwm_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            pre_cnt_q <= pre_cnt_d;
            idx_q     <= idx_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign idx_o        = idx_q;
    assign pwm_cnt_o    = pwm_cnt_q;
    assign slot_start_o = (pre_cnt_q == '0);
    assign frame_end_o  = pre_wrap && idx_last;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: a double-buffered digit image with tear-free frame swaps,
// PWM brightness and a blank first cycle in every slot.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int  NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int  SEG_W      = DEF_SEG_W,
    parameter int  PRESCALE   = DEF_PRESCALE,
    parameter int  BRIGHT_W   = DEF_BRIGHT_W,
    localparam int AW         = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [SEG_W-1:0]      wr_data,
    input  logic                  swap,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [SEG_W-1:0]      segm,
    output logic                  frame_tick,
    output logic                  swap_pending
);

    logic [AW-1:0]         idx;
    logic [BRIGHT_W-1:0]   pwm_cnt;
    logic                  slot_start;
    logic                  frame_end;

    logic [SEG_W-1:0]      shadow_q [NUM_DIGITS];
    logic [SEG_W-1:0]      active_q [NUM_DIGITS];

    logic                  wr_hit;
    logic                  do_copy;
    logic                  lit;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [SEG_W-1:0]      segm_q, segm_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  swap_pending_q, swap_pending_d;

    scan_timebase #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .BRIGHT_W   (BRIGHT_W)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .idx_o        (idx),
        .pwm_cnt_o    (pwm_cnt),
        .slot_start_o (slot_start),
        .frame_end_o  (frame_end)
    );

    always_comb begin
        wr_hit  = wr_en && ({1'b0, wr_addr} < (AW + 1)'(NUM_DIGITS));
        // A swap that arrives on the frame-end edge is served by that same copy.
        do_copy = frame_end && (swap_pending_q || swap);
        swap_pending_d = frame_end ? 1'b0 : (swap_pending_q || swap);
        frame_tick_d   = frame_end;

        lit    = enable && !slot_start && (pwm_cnt <= brightness);
        sel_d  = '0;
        segm_d = '0;
        if (lit) begin
            sel_d  = NUM_DIGITS'(onehot_sel(32'(idx)));
            segm_d = active_q[idx];
        end
    end

    // NOTE: both banks are reset explicitly, so the display is guaranteed blank after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (do_copy) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (wr_hit) begin
                shadow_q[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q          <= '0;
            segm_q         <= '0;
            frame_tick_q   <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            sel_q          <= sel_d;
            segm_q         <= segm_d;
            frame_tick_q   <= frame_tick_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    assign sel          = sel_q;
    assign segm         = segm_q;
    assign frame_tick   = frame_tick_q;
    assign swap_pending = swap_pending_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl.
// The main instance is 4 digits x 8 clocks with 2-bit brightness; a 5-digit instance covers out-of-range addresses.
module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable, wr_en, swap;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] brightness;
    logic [3:0] sel;
    logic [7:0] segm;
    logic       frame_tick, swap_pending;

    logic       en5, wr_en5, swap5;
    logic [2:0] wr_addr5;
    logic [7:0] wr_data5;
    logic [1:0] br5;
    logic [4:0] sel5;
    logic [7:0] segm5;
    logic       tick5, pend5;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [7:0] exp_pat [4];

    seg7_scan_ctrl #(.NUM_DIGITS(4), .SEG_W(8), .PRESCALE(8), .BRIGHT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap(swap), .brightness(brightness), .sel(sel), .segm(segm),
        .frame_tick(frame_tick), .swap_pending(swap_pending)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(5), .SEG_W(8), .PRESCALE(4), .BRIGHT_W(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .enable(en5), .wr_en(wr_en5), .wr_addr(wr_addr5),
        .wr_data(wr_data5), .swap(swap5), .brightness(br5), .sel(sel5), .segm(segm5),
        .frame_tick(tick5), .swap_pending(pend5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges since reset release; outputs after edge n reflect the state after n-1 edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [3:0] m_sel(input int n, input logic en, input logic [1:0] br);
        int k;
        k = n - 1;
        if (!en || (k % 8) == 0 || (k % 4) > int'(br)) return 4'b0000;
        return 4'(1 << ((k / 8) % 4));
    endfunction

    function automatic logic [7:0] m_segm(input int n, input logic en, input logic [1:0] br);
        if (m_sel(n, en, br) == 4'b0000) return 8'h00;
        return exp_pat[((n - 1) / 8) % 4];
    endfunction

    function automatic logic m_tick(input int n);
        return (n % 32) == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int phase, input string tag);
        for (int t = 0; t < 64 && (cyc % 32) != phase; t++) step();
        checks++;
        if ((cyc % 32) != phase) begin
            errors++;
            $display("FAIL %s align got phase %0d want %0d", tag, cyc % 32, phase);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; brightness = 2'd3; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; swap = 1'b0;
        en5 = 1'b1; br5 = 2'd3; wr_en5 = 1'b0; wr_addr5 = '0; wr_data5 = '0; swap5 = 1'b0;
        for (int i = 0; i < 4; i++) exp_pat[i] = 8'h00;
        repeat (3) step();
        checks += 5;
        if (sel !== 4'b0000)     begin errors++; $display("FAIL reset sel got %b want 0000", sel); end
        if (segm !== 8'h00)      begin errors++; $display("FAIL reset segm got %h want 00", segm); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset frame_tick got %b want 0", frame_tick); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset swap_pending got %b want 0", swap_pending); end
        if (sel5 !== 5'b00000)   begin errors++; $display("FAIL reset sel5 got %b want 00000", sel5); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame_ticks();
        for (int i = 0; i < 96; i++) begin
            step();
            checks += 3;
            if (sel !== m_sel(cyc, enable, brightness)) begin
                errors++; $display("FAIL ticks sel cyc=%0d got %b want %b", cyc, sel, m_sel(cyc, enable, brightness));
            end
            if (segm !== 8'h00) begin
                errors++; $display("FAIL ticks segm cyc=%0d got %h want 00", cyc, segm);
            end
            if (frame_tick !== m_tick(cyc)) begin
                errors++; $display("FAIL ticks frame_tick cyc=%0d got %b want %b", cyc, frame_tick, m_tick(cyc));
            end
        end
    endtask

    task automatic test_swap_update();
        logic done;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = SEG7_GLYPH[i];
            step();
        end
        wr_en = 1'b0;
        swap = 1'b1;
        step();
        swap = 1'b0;
        checks++;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL swap pending got %b want 1", swap_pending); end
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            step();
            checks++;
            if (segm !== 8'h00) begin errors++; $display("FAIL swap early segm cyc=%0d got %h want 00", cyc, segm); end
            done = frame_tick;
        end
        checks += 2;
        if (!done || (cyc % 32) != 0) begin
            errors++; $display("FAIL swap tick got done=%b cyc=%0d want tick at multiple of 32", done, cyc);
        end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap pending_clear got %b want 0", swap_pending); end
        exp_pat[0] = 8'h3F; exp_pat[1] = 8'h06; exp_pat[2] = 8'h5B; exp_pat[3] = 8'h4F;
        for (int i = 0; i < 32; i++) begin
            step();
            checks += 3;
            if (sel !== m_sel(cyc, enable, brightness)) begin
                errors++; $display("FAIL swap sel cyc=%0d got %b want %b", cyc, sel, m_sel(cyc, enable, brightness));
            end
            if (segm !== m_segm(cyc, enable, brightness)) begin
                errors++; $display("FAIL swap segm cyc=%0d got %h want %h", cyc, segm, m_segm(cyc, enable, brightness));
            end
            if (frame_tick !== m_tick(cyc)) begin
                errors++; $display("FAIL swap frame_tick cyc=%0d got %b want %b", cyc, frame_tick, m_tick(cyc));
            end
        end
    endtask

    task automatic test_brightness();
        brightness = 2'd0;
        for (int i = 0; i < 32; i++) begin
            step();
            checks += 2;
            if (sel !== m_sel(cyc, enable, brightness)) begin
                errors++; $display("FAIL bright sel cyc=%0d got %b want %b", cyc, sel, m_sel(cyc, enable, brightness));
            end
            if (segm !== m_segm(cyc, enable, brightness)) begin
                errors++; $display("FAIL bright segm cyc=%0d got %h want %h", cyc, segm, m_segm(cyc, enable, brightness));
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_write_on_frame_end();
        logic done;
        step_to(2, "wfe");
        swap = 1'b1;
        step();
        swap = 1'b0;
        checks++;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL wfe pending got %b want 1", swap_pending); end
        step_to(31, "wfe");
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        checks += 2;
        if (frame_tick !== 1'b1)   begin errors++; $display("FAIL wfe tick got %b want 1", frame_tick); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL wfe pending_clear got %b want 0", swap_pending); end
        for (int i = 0; i < 32; i++) begin
            step();
            checks++;
            if (segm !== m_segm(cyc, enable, brightness)) begin
                errors++; $display("FAIL wfe old_digit segm cyc=%0d got %h want %h", cyc, segm, m_segm(cyc, enable, brightness));
            end
        end
        step();
        swap = 1'b1; step(); swap = 1'b0; step();
        swap = 1'b1; step(); swap = 1'b0;
        checks++;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL wfe collapse pending got %b want 1", swap_pending); end
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            step();
            done = frame_tick;
        end
        checks += 2;
        if (!done) begin errors++; $display("FAIL wfe second_tick got none want tick within 40 cycles"); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL wfe collapse clear got %b want 0", swap_pending); end
        exp_pat[2] = 8'hFF;
        for (int i = 0; i < 32; i++) begin
            step();
            checks++;
            if (segm !== m_segm(cyc, enable, brightness)) begin
                errors++; $display("FAIL wfe new_digit segm cyc=%0d got %h want %h", cyc, segm, m_segm(cyc, enable, brightness));
            end
        end
    endtask

    task automatic test_swap_on_frame_end();
        step_to(1, "sfe");
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        step_to(31, "sfe");
        swap = 1'b1;
        step();
        swap = 1'b0;
        checks += 2;
        if (frame_tick !== 1'b1)   begin errors++; $display("FAIL sfe tick got %b want 1", frame_tick); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL sfe pending got %b want 0", swap_pending); end
        exp_pat[0] = 8'h77;
        for (int i = 0; i < 32; i++) begin
            step();
            checks += 2;
            if (segm !== m_segm(cyc, enable, brightness)) begin
                errors++; $display("FAIL sfe segm cyc=%0d got %h want %h", cyc, segm, m_segm(cyc, enable, brightness));
            end
            if (swap_pending !== 1'b0) begin
                errors++; $display("FAIL sfe pending_after cyc=%0d got %b want 0", cyc, swap_pending);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic done;
        logic [4:0] e_sel;
        logic [7:0] e_segm;
        int k;
        wr_en5 = 1'b1;
        wr_addr5 = 3'd5; wr_data5 = 8'hFF; step();
        wr_addr5 = 3'd7; wr_data5 = 8'hAA; step();
        wr_addr5 = 3'd4; wr_data5 = 8'h66; step();
        wr_en5 = 1'b0;
        swap5 = 1'b1;
        step();
        swap5 = 1'b0;
        done = tick5;
        for (int t = 0; t < 25 && !done; t++) begin
            step();
            done = tick5;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL range tick got none want tick within 25 cycles"); end
        for (int i = 0; i < 20; i++) begin
            step();
            k = cyc - 1;
            e_sel  = ((k % 4) == 0) ? 5'b00000 : 5'(1 << ((k / 4) % 5));
            e_segm = ((k % 4) != 0 && ((k / 4) % 5) == 4) ? 8'h66 : 8'h00;
            checks += 2;
            if (sel5 !== e_sel) begin
                errors++; $display("FAIL range sel5 cyc=%0d got %b want %b", cyc, sel5, e_sel);
            end
            if (segm5 !== e_segm) begin
                errors++; $display("FAIL range segm5 cyc=%0d got %h want %h", cyc, segm5, e_segm);
            end
        end
    endtask

    task automatic test_enable_gap();
        step_to(0, "gap");
        for (int i = 0; i < 32; i++) begin
            enable = (i >= 10 && i < 13) ? 1'b0 : 1'b1;
            step();
            checks += 3;
            if (sel !== m_sel(cyc, enable, brightness)) begin
                errors++; $display("FAIL gap sel cyc=%0d got %b want %b", cyc, sel, m_sel(cyc, enable, brightness));
            end
            if (segm !== m_segm(cyc, enable, brightness)) begin
                errors++; $display("FAIL gap segm cyc=%0d got %h want %h", cyc, segm, m_segm(cyc, enable, brightness));
            end
            if (frame_tick !== m_tick(cyc)) begin
                errors++; $display("FAIL gap frame_tick cyc=%0d got %b want %b", cyc, frame_tick, m_tick(cyc));
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        step_to(10, "rmf");
        swap = 1'b1;
        step();
        swap = 1'b0;
        step();
        step();
        checks += 2;
        if (swap_pending !== 1'b1) begin errors++; $display("FAIL rmf pending got %b want 1", swap_pending); end
        if (segm !== m_segm(cyc, enable, brightness)) begin
            errors++; $display("FAIL rmf pre_reset segm got %h want %h", segm, m_segm(cyc, enable, brightness));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (sel !== 4'b0000)       begin errors++; $display("FAIL rmf sel got %b want 0000", sel); end
        if (segm !== 8'h00)        begin errors++; $display("FAIL rmf segm got %h want 00", segm); end
        if (frame_tick !== 1'b0)   begin errors++; $display("FAIL rmf tick got %b want 0", frame_tick); end
        if (swap_pending !== 1'b0) begin errors++; $display("FAIL rmf pending_clear got %b want 0", swap_pending); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) exp_pat[i] = 8'h00;
        for (int i = 0; i < 64; i++) begin
            swap = (i == 2) ? 1'b1 : 1'b0;
            step();
            checks += 3;
            if (sel !== m_sel(cyc, enable, brightness)) begin
                errors++; $display("FAIL rmf sel cyc=%0d got %b want %b", cyc, sel, m_sel(cyc, enable, brightness));
            end
            if (segm !== 8'h00) begin
                errors++; $display("FAIL rmf banks segm cyc=%0d got %h want 00", cyc, segm);
            end
            if (frame_tick !== m_tick(cyc)) begin
                errors++; $display("FAIL rmf frame_tick cyc=%0d got %b want %b", cyc, frame_tick, m_tick(cyc));
            end
        end
        swap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_ticks();
        test_swap_update();
        test_brightness();
        test_write_on_frame_end();
        test_swap_on_frame_end();
        test_out_of_range();
        test_enable_gap();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
